hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Control end of the ID_EX pipeline register: decides each cycle whether ID_EX
//  captures the decoded instruction, captures a bubble, or is flushed. Detects
//  load-use hazards between the EX and ID instructions and stalls PC and IF/ID.
//  Also applies taken-branch flushes resolved in MEM. Drives the stall and flush
//  inputs of the PC, IF_ID, ID_EX and EX_MEM registers.
// PARAMETERS
//  STALL_CYCLES  1   cycles of stall per load-use hazard (1..15); >1 models slow load data
// PORTS
//  clk               in   1   pipeline clock, rising edge
//  rst               in   1   asynchronous reset, active low
//  ID_order          in   32  instruction word in ID
//  EX_order          in   32  instruction word in EX (ID_EX output)
//  EX_MemRead        in   1   EX instruction is a load
//  MEM_branch_taken  in   1   branch resolved taken in MEM this cycle
//  pc_write          out  1   1 = PC advances
//  ifid_write        out  1   1 = IF_ID captures
//  ifid_flush        out  1   1 = IF_ID loads NOP
//  idex_bubble       out  1   1 = ID_EX captures all-zero controls (bubble)
//  exmem_flush       out  1   1 = EX_MEM clears its control bits
//  stall_count       out  32  stall cycles since reset (see CONFIGURATION)
//  flush_count       out  32  taken-branch flushes since reset (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: asynchronous, active low. While rst=0: state RUN, cnt=0, counters 0,
//    pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, exmem_flush=0.
//  - Field decode: rs=[25:21], rt=[20:16], op=[31:26]. ID uses rt iff
//    op = 6'b000000 (R-type), 6'b000100 (beq) or 6'b101011 (sw).
//  - lu_hazard = EX_MemRead & EX.rt!=0 & (EX.rt==ID.rs | (ID uses rt & EX.rt==ID.rt)).
//  - States: RUN, STALL; 4-bit cnt. Outputs combinational from state + inputs.
//  - Default (RUN, no event): pc_write=1, ifid_write=1, all flush/bubble=0.
//  - MEM_branch_taken=1 (any state): ifid_flush=1, idex_bubble=1, exmem_flush=1,
//    pc_write=1, ifid_write=1; next state RUN, cnt=0. Branch beats hazard/stall.
//  - RUN & lu_hazard & no branch: pc_write=0, ifid_write=0, idex_bubble=1 this cycle;
//    if STALL_CYCLES=1 stay RUN, else next STALL with cnt=STALL_CYCLES-1.
//  - STALL & no branch: pc_write=0, ifid_write=0, idex_bubble=1; cnt decrements;
//    cnt==1 -> next RUN. Total frozen cycles per hazard = STALL_CYCLES exactly.
//  - Hazard is not re-evaluated in STALL (EX holds the bubble); first RUN cycle
//    re-evaluates normally (back-to-back loads stall again).
//  - Reset mid-stall: immediately RUN, cnt=0; outputs follow reset values.
// CONFIGURATION
//  - HAZARD_PERF_EN defined: stall_count +1 per cycle with pc_write=0 and rst=1 and
//    no branch; flush_count +1 per cycle with MEM_branch_taken=1; both wrap at 2^32.
//  - Not defined: counters not built; stall_count and flush_count tied to 32'd0.
// TESTING
//  - Reset: rst=0 mid-stall -> state RUN, pc_write=0, idex_bubble=1; release -> pc_write=1.
//  - STALL_CYCLES=1: EX_order=32'h8D280000 (lw $8), EX_MemRead=1, ID_order=32'h010B5020
//    (add $10,$8,$11) -> one cycle pc_write=0, ifid_write=0, idex_bubble=1; then RUN.
//  - No hazard: same lw, ID_order=32'h012B5020 (add $10,$9,$11) -> pc_write=1, no bubble;
//    lw with rt=0 (32'h8D200000) vs ID rs=0 -> no stall.
//  - rt-only use: ID addi $8-rt instruction (op 001000, rt=8) -> no stall; ID sw with rt=8 -> stall.
//  - STALL_CYCLES=3: hazard -> exactly 3 cycles pc_write=0; branch_taken in 2nd cycle ->
//    all flushes=1 that cycle, pc_write=1, RUN next cycle.
//  - HAZARD_PERF_EN: 2 hazards (STALL_CYCLES=3) + 1 branch -> stall_count=6, flush_count=1;
//    without macro both read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ID_EX control: load-use stall detection, branch flush and pipeline-register enables.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ID_order,
    input  logic [31:0] EX_order,
    input  logic        EX_MemRead,
    input  logic        MEM_branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_flush,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    // state | meaning
    // RUN   | normal issue; load-use hazard evaluated each cycle
    // STALL | extra frozen cycles of a multi-cycle load-use stall, cnt = cycles left
    typedef enum logic {RUN, STALL} state_t;

    localparam logic [3:0] STALL_LOAD = 4'(STALL_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic [5:0] id_op;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, lu_hazard;
    logic       unused_bits;

    assign id_op = ID_order[31:26];
    assign id_rs = ID_order[25:21];
    assign id_rt = ID_order[20:16];
    assign ex_rt = EX_order[20:16];
    assign unused_bits = ^{ID_order[15:0], EX_order[31:21], EX_order[15:0]};

    assign id_uses_rt = (id_op == 6'b000000) || (id_op == 6'b000100) || (id_op == 6'b101011);
    assign lu_hazard  = EX_MemRead && (ex_rt != 5'd0) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs depend on rst as well so the pipeline is held frozen while in reset.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        if (!rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_nxt   = RUN;
            cnt_nxt     = 4'd0;
        end else if (MEM_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            state_nxt   = RUN;
            cnt_nxt     = 4'd0;
        end else if (state == STALL) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            cnt_nxt     = cnt - 4'd1;
            if (cnt == 4'd1) begin
                state_nxt = RUN;
                cnt_nxt   = 4'd0;
            end
        end else if (lu_hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (STALL_CYCLES > 1) begin
                state_nxt = STALL;
                cnt_nxt   = STALL_LOAD;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (!pc_write && !MEM_branch_taken) stall_q <= stall_q + 32'd1;
            if (MEM_branch_taken)               flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;
`else
    assign stall_count = 32'd0;
    assign flush_count = 32'd0;
`endif

endmodule
